// File: rtl/adc_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_scan_pkg
//  Purpose  : Shared types and constants for the ADC scan sequencer
//             (controller state encoding, default channel index type,
//             accumulator width helper).
//  Revision : 1.0 - initial release
// ============================================================================
package adc_scan_pkg;

  // Default build values; the top-level parameters start from these.
  localparam int unsigned c_RESOLUTION    = 8;
  localparam int unsigned c_NUM_CH        = 4;
  localparam int unsigned c_SETTLE_CYCLES = 2;
  localparam int unsigned c_AVG_LOG2_MAX  = 3;

  // Channel index for the default channel count.
  typedef logic [$clog2(c_NUM_CH)-1:0] ch_idx_t;

  // Controller states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  // The accumulator must hold 2^avg_max full-scale samples without overflow.
  function automatic int unsigned acc_width(input int unsigned res,
                                            input int unsigned avg_max);
    return res + avg_max;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scan_next_ch.sv
`default_nettype none
// ============================================================================
//  Module   : adc_scan_next_ch
//  Purpose  : Combinational next-enabled-channel finder.
//             i_wrap = 1 : returns the lowest enabled channel.
//             i_wrap = 0 : returns the lowest enabled channel above i_cur.
//  Ports    : i_mask  [NUM_CH]        enabled channel mask
//             i_cur   [$clog2(NUM_CH)] current channel
//             i_wrap                  search from channel 0
//             o_nxt   [$clog2(NUM_CH)] channel found (0 when none)
//             o_found                 a qualifying channel exists
//  Revision : 1.0 - initial release
// ============================================================================
module adc_scan_next_ch
  import adc_scan_pkg::*;
#(
  parameter int unsigned NUM_CH = c_NUM_CH
) (
  input  logic [NUM_CH-1:0]         i_mask,
  input  logic [$clog2(NUM_CH)-1:0] i_cur,
  input  logic                      i_wrap,
  output logic [$clog2(NUM_CH)-1:0] o_nxt,
  output logic                      o_found
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  // Descending scan so the last hit written is the lowest qualifying index.
  always_comb begin
    o_found = 1'b0;
    o_nxt   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_wrap || (i > int'(i_cur)))) begin
        o_found = 1'b1;
        o_nxt   = CH_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adc_scan_ctrl
//  Purpose  : Multi-channel scan sequencer for the SAR ADC. Selects a mux
//             channel, waits for settling, pulses the ADC start, collects the
//             result (optionally averaging 2^N samples) and delivers
//             {channel, result} on a valid/ready stream.
//  Config   : ADC_SCAN_AVG_EN - when defined, enables 2^avg_log2_i sample
//             averaging; otherwise one sample per channel, avg_log2_i unused.
//  Ports    : clk_i, rst_ni (async, active-low)
//             scan_start_i, scan_abort_i, cont_i, ch_mask_i, avg_log2_i
//             mux_sel_o, adc_start_o, adc_rdy_i, adc_result_i  (adc side)
//             res_valid_o, res_ready_i, res_ch_o, res_data_o   (stream)
//             busy_o, done_o
//  Revision : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int unsigned RESOLUTION    = c_RESOLUTION,
  parameter int unsigned NUM_CH        = c_NUM_CH,
  parameter int unsigned SETTLE_CYCLES = c_SETTLE_CYCLES,
  parameter int unsigned AVG_LOG2_MAX  = c_AVG_LOG2_MAX
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              scan_start_i,
  input  logic                              scan_abort_i,
  input  logic                              cont_i,
  input  logic [NUM_CH-1:0]                 ch_mask_i,
  input  logic [$clog2(AVG_LOG2_MAX+1)-1:0] avg_log2_i,
  output logic [$clog2(NUM_CH)-1:0]         mux_sel_o,
  output logic                              adc_start_o,
  input  logic                              adc_rdy_i,
  input  logic [RESOLUTION-1:0]             adc_result_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [$clog2(NUM_CH)-1:0]         res_ch_o,
  output logic [RESOLUTION-1:0]             res_data_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST =
    (SETTLE_CYCLES > 0) ? SET_W'(SETTLE_CYCLES - 1) : '0;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_mask;
  logic                r_wrap;        // finder searches from channel 0
  logic                r_first;       // first selection of this scan
  logic                r_abort;       // sticky abort request
  logic                r_rdy_prev;
  logic [SET_W-1:0]    r_settle_cnt;

  logic [CH_W-1:0]     w_nxt_ch;
  logic                w_found;
  logic                w_abort;
  logic                w_rdy_rise;

  assign w_abort    = r_abort | scan_abort_i;
  assign w_rdy_rise = adc_rdy_i & ~r_rdy_prev;

  adc_scan_next_ch #(
    .NUM_CH (NUM_CH)
  ) u_next_ch (
    .i_mask  (r_mask),
    .i_cur   (mux_sel_o),
    .i_wrap  (r_wrap),
    .o_nxt   (w_nxt_ch),
    .o_found (w_found)
  );

`ifdef ADC_SCAN_AVG_EN
  localparam int unsigned AVG_W = $clog2(AVG_LOG2_MAX + 1);
  localparam int unsigned ACC_W = acc_width(RESOLUTION, AVG_LOG2_MAX);
  localparam int unsigned CNT_W = AVG_LOG2_MAX + 1;

  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_smp_cnt;
  logic [AVG_W-1:0]      r_avg;
  logic [ACC_W-1:0]      w_acc_sum;
  logic [CNT_W-1:0]      w_smp_last;
  logic [AVG_W-1:0]      w_avg_clamped;
  logic [RESOLUTION-1:0] w_avg_res;

  assign w_avg_clamped = (32'(avg_log2_i) > AVG_LOG2_MAX) ? AVG_W'(AVG_LOG2_MAX)
                                                          : avg_log2_i;
  assign w_acc_sum     = r_acc + ACC_W'(adc_result_i);
  assign w_smp_last    = (CNT_W'(1) << r_avg) - CNT_W'(1);
  // Truncating divide by 2^avg.
  assign w_avg_res     = RESOLUTION'(w_acc_sum >> r_avg);
`else
  logic w_unused_avg;
  assign w_unused_avg = ^avg_log2_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_wrap       <= 1'b0;
      r_first      <= 1'b0;
      r_abort      <= 1'b0;
      r_rdy_prev   <= 1'b0;
      r_settle_cnt <= '0;
      mux_sel_o    <= '0;
      adc_start_o  <= 1'b0;
      res_valid_o  <= 1'b0;
      res_ch_o     <= '0;
      res_data_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      r_acc        <= '0;
      r_smp_cnt    <= '0;
      r_avg        <= '0;
`endif
    end else begin
      r_rdy_prev  <= adc_rdy_i;
      adc_start_o <= 1'b0;
      done_o      <= 1'b0;

      if ((r_state != S_IDLE) && scan_abort_i) begin
        r_abort <= 1'b1;
      end

      // Terminations below rewrite r_abort/busy_o/done_o; being later in the
      // block they override the defaults above.
      case (r_state)
        S_IDLE: begin
          if (scan_start_i && (ch_mask_i != '0)) begin
            r_mask  <= ch_mask_i;
            r_wrap  <= 1'b1;
            r_first <= 1'b1;
            r_abort <= 1'b0;
            busy_o  <= 1'b1;
            r_state <= S_SELECT;
`ifdef ADC_SCAN_AVG_EN
            r_avg   <= w_avg_clamped;
`endif
          end
        end

        S_SELECT: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            r_abort <= 1'b0;
          end else begin
            mux_sel_o <= w_nxt_ch;
            r_wrap    <= 1'b0;
            r_first   <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            r_acc     <= '0;
            r_smp_cnt <= '0;
`endif
            // Re-selecting the same channel mid-scan needs no settling.
            if ((SETTLE_CYCLES == 0) || (!r_first && (w_nxt_ch == mux_sel_o))) begin
              adc_start_o <= 1'b1;
              r_state     <= S_START;
            end else begin
              r_settle_cnt <= '0;
              r_state      <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            r_abort <= 1'b0;
          end else if (r_settle_cnt == SET_LAST) begin
            adc_start_o <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end

        // adc_start_o is high for exactly this state's cycle.
        S_START: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (w_rdy_rise) begin
            if (w_abort) begin
              // Conversion is complete; its result is discarded.
              r_state <= S_IDLE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              r_abort <= 1'b0;
            end else begin
`ifdef ADC_SCAN_AVG_EN
              if (r_smp_cnt == w_smp_last) begin
                res_data_o  <= w_avg_res;
                res_ch_o    <= mux_sel_o;
                res_valid_o <= 1'b1;
                r_state     <= S_OUTPUT;
              end else begin
                r_acc       <= w_acc_sum;
                r_smp_cnt   <= r_smp_cnt + 1'b1;
                adc_start_o <= 1'b1;
                r_state     <= S_START;
              end
`else
              res_data_o  <= adc_result_i;
              res_ch_o    <= mux_sel_o;
              res_valid_o <= 1'b1;
              r_state     <= S_OUTPUT;
`endif
            end
          end
        end

        S_OUTPUT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            if (w_abort || (!w_found && !cont_i)) begin
              r_state <= S_IDLE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              r_abort <= 1'b0;
            end else if (w_found) begin
              r_state <= S_SELECT;
            end else begin
              // End of pass in continuous mode: wrap to the lowest channel.
              r_wrap  <= 1'b1;
              r_state <= S_SELECT;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
